// File: rtl/sop_frame_sequencer.sv
// -----------------------------------------------------------------------------
// sop_frame_sequencer
//
// Frame controller for an external 4-tap sum-of-products datapath
//   final_sum = c11*x[n] + c12*x[n-1] + c21*x[n-2] + c22*x[n-3]
// whose output is registered once (SOP_LATENCY cycles from sop_data_in to
// sop_final_sum).
//
// Each frame clears the datapath delay line, streams frame_len samples that
// must arrive back-to-back, then feeds three zeros so the whole convolution
// (frame_len + 3 results) comes out. Every result is tagged with m_valid.
// Coefficients are written into a shadow bank at any time and copied into
// the active bank only when a frame is accepted.
//
// Optional feature (macro SOP_FRAME_CNT_EN): adds output frame_cnt[15:0],
// counting completed (non-aborted) frames, wrapping at 0xFFFF.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, frame_len    frame request; length sampled on acceptance
//   busy, done          controller not idle; one-cycle end-of-frame/abort pulse
//   err_underrun        sticky underrun flag, cleared by the next accepted start
//   cfg_we/addr/data    shadow coefficient write (0=c11 1=c12 2=c21 3=c22)
//   s_valid/s_ready/s_data   sample input handshake (s_ready only in RUN)
//   sop_clr             datapath clear (drives the datapath reset)
//   sop_data_in         datapath sample input
//   sop_coef11..22      active coefficients
//   sop_final_sum       datapath result
//   m_valid, m_data     result stream (m_data is sop_final_sum)
// -----------------------------------------------------------------------------
module sop_frame_sequencer #(
  parameter int DATA_WIDTH  = 4,
  parameter int LEN_W       = 8,
  parameter int SOP_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        frame_len,
  output logic                    busy,
  output logic                    done,
  output logic                    err_underrun,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_addr,
  input  logic [DATA_WIDTH-1:0]   cfg_data,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_ready,
  output logic                    sop_clr,
  output logic [DATA_WIDTH-1:0]   sop_data_in,
  output logic [DATA_WIDTH-1:0]   sop_coef11,
  output logic [DATA_WIDTH-1:0]   sop_coef12,
  output logic [DATA_WIDTH-1:0]   sop_coef21,
  output logic [DATA_WIDTH-1:0]   sop_coef22,
  input  logic [2*DATA_WIDTH+1:0] sop_final_sum,
  output logic                    m_valid,
  output logic [2*DATA_WIDTH+1:0] m_data
`ifdef SOP_FRAME_CNT_EN
  ,
  output logic [15:0]             frame_cnt
`endif
);

  localparam logic [LEN_W-1:0] CNT_ZERO   = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] FLUSH_LAST = LEN_W'(2'd2);
  // The drain waits one extra cycle for the tag flop that sits beside
  // sop_data_in, so done lands the cycle after the last m_valid.
  localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(SOP_LATENCY);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4,
    ST_ABORT = 3'd5
  } state_e;

  state_e                        state_q, state_d;
  logic [LEN_W-1:0]              len_q, len_d;
  logic [LEN_W-1:0]              cnt_q, cnt_d, cnt_inc;
  logic [3:0][DATA_WIDTH-1:0]    shadow_q, shadow_d;
  logic [3:0][DATA_WIDTH-1:0]    active_q, active_d;
  logic                          err_q, err_d;
  logic                          done_q, done_d;
  logic                          busy_q, busy_d;
  logic                          s_ready_q, s_ready_d;
  logic                          sop_clr_q, sop_clr_d;
  logic [DATA_WIDTH-1:0]         sop_data_q, sop_data_d;
  logic                          tag_q, tag_d;
  logic [SOP_LATENCY-1:0]        vpipe_q, vpipe_d;
  logic                          accept;
  logic                          push;
  logic                          flush_pipe;
  logic                          frame_complete;

  assign accept         = (state_q == ST_IDLE) && start && (frame_len != CNT_ZERO);
  assign cnt_inc        = cnt_q + CNT_ONE;
  assign frame_complete = (state_q == ST_DRAIN) && (state_d == ST_IDLE);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_CLEAR;
        else        state_d = ST_IDLE;
      end
      ST_CLEAR: state_d = ST_RUN;
      ST_RUN: begin
        // The datapath has no enable, so a missing sample ends the frame.
        if (!s_valid)              state_d = ST_ABORT;
        else if (cnt_inc == len_q) state_d = ST_FLUSH;
        else                       state_d = ST_RUN;
      end
      ST_FLUSH: begin
        if (cnt_q == FLUSH_LAST) state_d = ST_DRAIN;
        else                     state_d = ST_FLUSH;
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) state_d = ST_IDLE;
        else                     state_d = ST_DRAIN;
      end
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded one cycle ahead so every output comes from a flop
  always_comb begin
    busy_d    = (state_d != ST_IDLE);
    s_ready_d = (state_d == ST_RUN);
    sop_clr_d = (state_d == ST_CLEAR) || (state_d == ST_ABORT);
    done_d    = frame_complete || (state_q == ST_ABORT);
    push      = ((state_q == ST_RUN) && s_valid) || (state_q == ST_FLUSH);
    if ((state_q == ST_RUN) && s_valid) begin
      sop_data_d = s_data;
    end else begin
      sop_data_d = {DATA_WIDTH{1'b0}};
    end
  end

  // Frame bookkeeping: length, counter, coefficient banks, error, valid pipe
  always_comb begin
    len_d    = len_q;
    err_d    = err_q;
    active_d = active_q;
    shadow_d = shadow_q;
    vpipe_d  = vpipe_q;

    if (cfg_we) begin
      shadow_d[cfg_addr] = cfg_data;
    end else begin
      shadow_d = shadow_q;
    end

    // Active bank takes the shadow as it was before this cycle's write.
    if (accept) begin
      len_d    = frame_len;
      err_d    = 1'b0;
      active_d = shadow_q;
    end else if ((state_q == ST_RUN) && !s_valid) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    // One counter serves RUN, FLUSH and DRAIN; it restarts on every transition.
    if (state_d != state_q) begin
      cnt_d = CNT_ZERO;
    end else if ((state_q == ST_RUN) || (state_q == ST_FLUSH) || (state_q == ST_DRAIN)) begin
      cnt_d = cnt_inc;
    end else begin
      cnt_d = CNT_ZERO;
    end

    // tag_q travels with sop_data_in; the pipe then matches the datapath latency.
    flush_pipe = (state_d == ST_ABORT) || (state_q == ST_ABORT);
    tag_d      = push && !flush_pipe;
    if (flush_pipe) begin
      vpipe_d = {SOP_LATENCY{1'b0}};
    end else begin
      vpipe_d[0] = tag_q;
      for (int i = 1; i < SOP_LATENCY; i++) begin
        vpipe_d[i] = vpipe_q[i-1];
      end
    end
  end

  // Registered datapath-control, status and coefficient state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= CNT_ZERO;
      cnt_q      <= CNT_ZERO;
      shadow_q   <= {(4*DATA_WIDTH){1'b0}};
      active_q   <= {(4*DATA_WIDTH){1'b0}};
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      s_ready_q  <= 1'b0;
      sop_clr_q  <= 1'b0;
      sop_data_q <= {DATA_WIDTH{1'b0}};
      tag_q      <= 1'b0;
      vpipe_q    <= {SOP_LATENCY{1'b0}};
    end else begin
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      err_q      <= err_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      s_ready_q  <= s_ready_d;
      sop_clr_q  <= sop_clr_d;
      sop_data_q <= sop_data_d;
      tag_q      <= tag_d;
      vpipe_q    <= vpipe_d;
    end
  end

`ifdef SOP_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Completed-frame counter next value (aborted frames are not counted)
  always_comb begin
    if (frame_complete) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Completed-frame counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign err_underrun = err_q;
  assign s_ready      = s_ready_q;
  assign sop_clr      = sop_clr_q;
  assign sop_data_in  = sop_data_q;
  assign sop_coef11   = active_q[0];
  assign sop_coef12   = active_q[1];
  assign sop_coef21   = active_q[2];
  assign sop_coef22   = active_q[3];
  assign m_valid      = vpipe_q[SOP_LATENCY-1];
  assign m_data       = sop_final_sum;

endmodule

// File: tb/tb_sop_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sop_frame_sequencer
//
// Self-checking bench for sop_frame_sequencer. A behavioural 4-tap datapath
// closes the loop; expected results come from a direct convolution of each
// frame's samples with the coefficients captured at frame start.
// -----------------------------------------------------------------------------
module tb_sop_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] frame_len;
  logic       busy, done, err_underrun;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [3:0] cfg_data;
  logic       s_valid;
  logic [3:0] s_data;
  logic       s_ready, sop_clr;
  logic [3:0] sop_data_in, sop_coef11, sop_coef12, sop_coef21, sop_coef22;
  logic [9:0] sop_final_sum;
  logic       m_valid;
  logic [9:0] m_data;
`ifdef SOP_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int ok_frames = 0;
  int model_shadow[4];
  int model_active[4];
  int frame_x[0:299];

  always #5 clk = ~clk;

  sop_frame_sequencer #(.DATA_WIDTH(4), .LEN_W(8), .SOP_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .busy(busy), .done(done), .err_underrun(err_underrun),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .sop_clr(sop_clr), .sop_data_in(sop_data_in),
    .sop_coef11(sop_coef11), .sop_coef12(sop_coef12),
    .sop_coef21(sop_coef21), .sop_coef22(sop_coef22),
    .sop_final_sum(sop_final_sum), .m_valid(m_valid), .m_data(m_data)
`ifdef SOP_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  // Behavioural datapath: 3-deep delay line plus registered sum, cleared by sop_clr.
  logic [3:0] dl1, dl2, dl3;
  always @(posedge clk or posedge sop_clr or posedge rst) begin
    if (rst || sop_clr) begin
      dl1 <= '0; dl2 <= '0; dl3 <= '0; sop_final_sum <= '0;
    end else begin
      sop_final_sum <= 10'(sop_coef11) * 10'(sop_data_in) + 10'(sop_coef12) * 10'(dl1)
                     + 10'(sop_coef21) * 10'(dl2) + 10'(sop_coef22) * 10'(dl3);
      dl1 <= sop_data_in; dl2 <= dl1; dl3 <= dl2;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [3:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 1'b0;
    model_shadow[a] = int'(d);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) frame_x[i] = int'($urandom_range(0, 15));
  endtask

  // cfg_idx: RUN cycle index of a shadow write, -2 = together with start, -1 = none.
  // underrun_at: RUN cycle index where s_valid is withheld (0 or 1), -1 = none.
  task automatic run_frame(input int n, input int underrun_at, input bit spam,
                           input int cfg_idx, input logic [1:0] cfg_a, input logic [3:0] cfg_d);
    int exp_q[$];
    int mv_cnt = 0, idx = 0, cyc = 0, last_mv = -100, first_mv = -1, acc;
    bit fin = 1'b0, clr_seen = 1'b0, aborted;
    aborted = (underrun_at >= 0);
    for (int k = 0; k < 4; k++) model_active[k] = model_shadow[k];
    if (!aborted) begin
      for (int i = 0; i < n + 3; i++) begin
        acc = 0;
        for (int k = 0; k < 4; k++)
          if ((i - k >= 0) && (i - k < n)) acc += model_active[k] * frame_x[i - k];
        exp_q.push_back(acc);
      end
    end
    start = 1'b1; frame_len = 8'(n); s_valid = 1'b0;
    if (cfg_idx == -2) begin
      cfg_we = 1'b1; cfg_addr = cfg_a; cfg_data = cfg_d; model_shadow[cfg_a] = int'(cfg_d);
    end
    step();
    start = 1'b0; cfg_we = 1'b0;
    check_eq("busy_on_start", busy, 1);
    check_eq("clr_on_start", sop_clr, 1);
    check_eq("err_cleared", err_underrun, 0);
    while (!fin && cyc < n + 40) begin
      s_valid = 1'b0; start = 1'b0; cfg_we = 1'b0; s_data = 4'($urandom);
      if (s_ready) begin
        if (idx != underrun_at) begin s_valid = 1'b1; s_data = 4'(frame_x[idx]); end
        if (idx == cfg_idx) begin
          cfg_we = 1'b1; cfg_addr = cfg_a; cfg_data = cfg_d; model_shadow[cfg_a] = int'(cfg_d);
        end
        if (spam) begin start = 1'b1; frame_len = 8'($urandom_range(0, 255)); end
        idx++;
      end
      step();
      cyc++;
      if (sop_clr) clr_seen = 1'b1;
      if (m_valid) begin
        mv_cnt++; last_mv = cyc;
        if (first_mv < 0) first_mv = cyc;
        if (exp_q.size() == 0) check_eq("extra_mvalid", 1, 0);
        else check_eq("m_data", m_data, exp_q.pop_front());
      end
      if (done) begin
        fin = 1'b1;
        check_eq("busy_at_done", busy, 0);
        if (aborted) begin
          check_eq("underrun_flag", err_underrun, 1);
          check_eq("abort_mvalid", mv_cnt, 0);
          check_eq("abort_clr", clr_seen, 1);
        end else begin
          check_eq("mvalid_count", mv_cnt, n + 3);
          check_eq("mvalid_contig", last_mv - first_mv, n + 2);
          check_eq("done_gap", cyc - last_mv, 1);
          check_eq("no_underrun", err_underrun, 0);
          check_eq("no_mid_clr", clr_seen, 0);
          ok_frames++;
        end
      end
    end
    if (!fin) check_eq("frame_timeout", 0, 1);
    start = 1'b0; s_valid = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    #1000000;
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; frame_len = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    s_valid = 1'b0; s_data = '0;
    for (int k = 0; k < 4; k++) model_shadow[k] = 0;
    step(); step();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err_underrun, 0);
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_sop_clr", sop_clr, 0);
    check_eq("rst_sop_data", sop_data_in, 0);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_coefs", {sop_coef11, sop_coef12, sop_coef21, sop_coef22}, 0);
    rst = 1'b0;
    step();

    // Coefficients 1,2,3,4 with three unit samples
    cfg_write(2'd0, 4'd1); cfg_write(2'd1, 4'd2); cfg_write(2'd2, 4'd3); cfg_write(2'd3, 4'd4);
    for (int i = 0; i < 3; i++) frame_x[i] = 1;
    run_frame(3, -1, 1'b0, -1, 2'd0, 4'd0);

    // Full-scale coefficients and samples
    for (int a = 0; a < 4; a++) cfg_write(2'(a), 4'd15);
    for (int i = 0; i < 4; i++) frame_x[i] = 15;
    run_frame(4, -1, 1'b0, -1, 2'd0, 4'd0);

    // Shadow write mid-frame only affects the next frame
    cfg_write(2'd0, 4'd1); cfg_write(2'd1, 4'd2); cfg_write(2'd2, 4'd3); cfg_write(2'd3, 4'd4);
    fill_random(4);
    run_frame(4, -1, 1'b0, 1, 2'd0, 4'd7);
    frame_x[0] = 1;
    run_frame(1, -1, 1'b0, -1, 2'd0, 4'd0);

    // Underrun on the second RUN cycle, then recovery
    fill_random(5);
    run_frame(5, 1, 1'b0, -1, 2'd0, 4'd0);
    fill_random(2);
    run_frame(2, -1, 1'b0, -1, 2'd0, 4'd0);

    // Zero-length start is ignored; start while busy is ignored
    start = 1'b1; frame_len = 8'd0;
    step();
    start = 1'b0;
    check_eq("zero_len_busy", busy, 0);
    check_eq("zero_len_done", done, 0);
    step();
    check_eq("zero_len_done2", done, 0);
    fill_random(6);
    run_frame(6, -1, 1'b1, -1, 2'd0, 4'd0);

    // Shadow write coincident with start is excluded from that frame
    fill_random(3);
    run_frame(3, -1, 1'b0, -2, 2'd3, 4'd9);
    fill_random(3);
    run_frame(3, -1, 1'b0, -1, 2'd0, 4'd0);

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 2) == 0)
        for (int a = 0; a < 4; a++) cfg_write(2'(a), 4'($urandom));
      n = int'($urandom_range(1, 12));
      fill_random(n);
      run_frame(n, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : -1,
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1,
                2'($urandom), 4'($urandom));
    end

    // Maximum-length frame
    fill_random(255);
    run_frame(255, -1, 1'b0, -1, 2'd0, 4'd0);

    // Asynchronous reset in the middle of RUN
    fill_random(6);
    start = 1'b1; frame_len = 8'd6;
    step();
    start = 1'b0;
    step();
    s_valid = 1'b1; s_data = 4'd9;
    step();
    s_data = 4'd3;
    step();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_s_ready", s_ready, 0);
    check_eq("arst_sop_data", sop_data_in, 0);
    check_eq("arst_sop_clr", sop_clr, 0);
    check_eq("arst_m_valid", m_valid, 0);
    check_eq("arst_coef11", sop_coef11, 0);
    s_valid = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) model_shadow[k] = 0;
    ok_frames = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("arst_no_done", done, 0);
      check_eq("arst_idle", busy, 0);
    end
    frame_x[0] = 1;
    run_frame(1, -1, 1'b0, -1, 2'd0, 4'd0);
    cfg_write(2'd1, 4'd5);
    fill_random(2);
    run_frame(2, -1, 1'b0, -1, 2'd0, 4'd0);
    fill_random(4);
    run_frame(4, 0, 1'b0, -1, 2'd0, 4'd0);
    fill_random(3);
    run_frame(3, -1, 1'b0, -1, 2'd0, 4'd0);
`ifdef SOP_FRAME_CNT_EN
    step();
    check_eq("frame_cnt", frame_cnt, ok_frames);
    check_eq("frame_cnt_3", frame_cnt, 3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
